// File: rtl/irq_pending_ctrl.sv
// Captures four interrupt sources (level or rising-edge), masks them, and turns the
// encoded winner into a held request / ack / done handshake. Request rises two edges after a source is sampled.
module irq_pending_ctrl #(
  parameter logic [3:0] EDGE_SRC = 4'b0000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_irq,
  input  logic [3:0] i_enable,
  input  logic       i_global_en,
  output logic [3:0] o_pending,
  input  logic [1:0] i_enc_id,
  output logic       o_irq_req,
  output logic [1:0] o_irq_id,
  input  logic       i_irq_ack,
  input  logic       i_irq_done,
  output logic       o_busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [3:0] prev_q;
  logic [1:0] id_q, id_d;
  logic       claim;
  logic [3:0] claim_mask;

  assign o_pending  = i_global_en ? (pend_q & i_enable) : 4'b0000;
  assign claim      = (state_q == REQ) && i_irq_ack;
  assign claim_mask = claim ? (4'b0001 << id_q) : 4'b0000;

  // A fresh edge in the claim cycle must survive, so the set term is OR'd after the clear.
  always_comb begin
    pend_d = (EDGE_SRC & ((i_irq & ~prev_q) | (pend_q & ~claim_mask)))
           | (~EDGE_SRC & i_irq);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (o_pending != 4'b0000) begin
          id_d    = i_enc_id;
          state_d = REQ;
        end
      end
      REQ: begin
        if (i_irq_ack) begin
          state_d = SERVICE;
        end else if (!o_pending[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (i_irq_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      pend_q  <= 4'b0000;
      prev_q  <= 4'b0000;
      id_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      prev_q  <= i_irq;
      id_q    <= id_d;
    end
  end

  assign o_irq_req = (state_q == REQ);
  assign o_busy    = (state_q == SERVICE);
  assign o_irq_id  = id_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Two instances (all-level and mixed edge/level) share stimulus; a reference model
// pushes expected outputs into a queue that a separate monitor drains and compares.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq = 4'b0000;
  logic [3:0] en = 4'b1111;
  logic       gen = 1'b1;
  logic       ack = 1'b0;
  logic       done = 1'b0;

  localparam logic [3:0] EDGE_A = 4'b0000;
  localparam logic [3:0] EDGE_B = 4'b0101;

  logic [3:0] pend_a, pend_b;
  logic [1:0] enc_a, enc_b, id_a, id_b;
  logic       req_a, req_b, busy_a, busy_b;

  always #5 clk = ~clk;

  // Environment encoder: highest index wins.
  function automatic logic [1:0] prio(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  assign enc_a = prio(pend_a);
  assign enc_b = prio(pend_b);

  irq_pending_ctrl #(.EDGE_SRC(EDGE_A)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_irq(irq), .i_enable(en), .i_global_en(gen),
    .o_pending(pend_a), .i_enc_id(enc_a), .o_irq_req(req_a), .o_irq_id(id_a),
    .i_irq_ack(ack), .i_irq_done(done), .o_busy(busy_a));

  irq_pending_ctrl #(.EDGE_SRC(EDGE_B)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_irq(irq), .i_enable(en), .i_global_en(gen),
    .o_pending(pend_b), .i_enc_id(enc_b), .o_irq_req(req_b), .o_irq_id(id_b),
    .i_irq_ack(ack), .i_irq_done(done), .o_busy(busy_b));

  // Reference model: per instance, which sources are latched, whether an interrupt
  // is being offered or served, and which source it is.
  bit [3:0] m_pend [2];
  bit [3:0] m_prev [2];
  bit       m_offering [2];
  bit       m_serving [2];
  bit [1:0] m_cur [2];

  typedef struct packed {
    logic       inst;
    logic [3:0] pend;
    logic       req;
    logic [1:0] id;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  function automatic bit [3:0] visible(input bit [3:0] p);
    return gen ? (p & en) : 4'b0000;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit [3:0] edges, vis, nxt;
      bit       claimed;
      edges = (k == 0) ? EDGE_A : EDGE_B;
      if (rst) begin
        m_pend[k] = '0; m_prev[k] = '0;
        m_offering[k] = 0; m_serving[k] = 0; m_cur[k] = 0;
      end else begin
        vis     = visible(m_pend[k]);
        claimed = m_offering[k] && ack;
        for (int n = 0; n < 4; n++) begin
          if (edges[n])
            nxt[n] = (irq[n] && !m_prev[k][n]) || (m_pend[k][n] && !(claimed && m_cur[k] == 2'(n)));
          else
            nxt[n] = irq[n];
        end
        if (m_serving[k]) begin
          if (done) m_serving[k] = 0;
        end else if (m_offering[k]) begin
          if (ack) begin
            m_offering[k] = 0; m_serving[k] = 1;
          end else if (!vis[m_cur[k]]) begin
            m_offering[k] = 0;
          end
        end else if (vis != 0) begin
          m_cur[k] = prio(vis);
          m_offering[k] = 1;
        end
        m_pend[k] = nxt;
        m_prev[k] = irq;
      end
    end
  endtask

  task automatic push_expect();
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e.inst = k[0];
      e.pend = visible(m_pend[k]);
      e.req  = m_offering[k];
      e.id   = m_cur[k];
      e.busy = m_serving[k];
      exp_q.push_back(e);
    end
  endtask

  // One clock: model absorbs the inputs sampled at this edge, then new inputs are applied.
  task automatic step(input bit r, input bit [3:0] i, input bit [3:0] e, input bit g,
                      input bit a, input bit d);
    @(posedge clk);
    model_edge();
    #1;
    rst = r; irq = i; en = e; gen = g; ack = a; done = d;
    push_expect();
  endtask

  task automatic idle(input int n, input bit [3:0] i);
    for (int c = 0; c < n; c++) step(0, i, 4'hF, 1, 0, 0);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.inst == 1'b0) begin
          chk("a_pending", pend_a, e.pend);
          chk("a_req", {3'b0, req_a}, {3'b0, e.req});
          chk("a_id", {2'b0, id_a}, {2'b0, e.id});
          chk("a_busy", {3'b0, busy_a}, {3'b0, e.busy});
        end else begin
          chk("b_pending", pend_b, e.pend);
          chk("b_req", {3'b0, req_b}, {3'b0, e.req});
          chk("b_id", {2'b0, id_b}, {2'b0, e.id});
          chk("b_busy", {3'b0, busy_b}, {3'b0, e.busy});
        end
      end
    end
  end

  initial begin : driver
    push_expect();
    // Reset with every source high, then release.
    for (int c = 0; c < 3; c++) step(1, 4'hF, 4'hF, 1, 0, 0);
    idle(4, 4'hF);
    step(0, 4'hF, 4'hF, 1, 1, 0);
    idle(2, 4'hF);
    step(0, 4'hF, 4'hF, 1, 0, 1);
    idle(3, 4'h0);
    // Reset mid-request.
    step(1, 4'h0, 4'hF, 1, 0, 0);
    idle(3, 4'h0);

    // Single pulse on source 0, then ack and done.
    step(0, 4'h1, 4'hF, 1, 0, 0);
    idle(3, 4'h0);
    step(0, 4'h0, 4'hF, 1, 1, 0);
    idle(2, 4'h0);
    step(0, 4'h0, 4'hF, 1, 0, 1);
    idle(3, 4'h0);

    // Sources 1 and 2 together: 2 first, then 1 after done.
    idle(3, 4'h6);
    step(0, 4'h6, 4'hF, 1, 1, 0);
    idle(2, 4'h2);
    step(0, 4'h2, 4'hF, 1, 0, 1);
    idle(3, 4'h2);
    step(0, 4'h2, 4'hF, 1, 1, 0);
    step(0, 4'h0, 4'hF, 1, 0, 1);
    idle(2, 4'h0);

    // Withdraw on source 3 drop; then drop and ack in the same cycle.
    idle(3, 4'h8);
    idle(3, 4'h0);
    idle(3, 4'h8);
    step(0, 4'h0, 4'hF, 1, 1, 0);
    idle(2, 4'h0);
    step(0, 4'h0, 4'hF, 1, 0, 1);
    idle(2, 4'h0);

    // Global enable gating, and per-source masking.
    for (int c = 0; c < 3; c++) step(0, 4'h3, 4'hF, 0, 0, 0);
    for (int c = 0; c < 3; c++) step(0, 4'h3, 4'hF, 1, 0, 0);
    for (int c = 0; c < 3; c++) step(0, 4'h3, 4'hD, 1, 0, 0);
    idle(2, 4'h0);

    // Source 0 re-pulses in its own ack cycle.
    step(0, 4'h1, 4'hF, 1, 0, 0);
    idle(2, 4'h0);
    step(0, 4'h1, 4'hF, 1, 1, 0);
    idle(2, 4'h0);
    step(0, 4'h0, 4'hF, 1, 0, 1);
    idle(3, 4'h0);
    step(0, 4'h0, 4'hF, 1, 1, 0);
    step(0, 4'h0, 4'hF, 1, 0, 1);
    idle(2, 4'h0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      bit [3:0] ri, re;
      bit rg, ra, rd, rr;
      ri = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      re = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      rg = ($urandom_range(0, 9) != 0);
      ra = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 99) == 0);
      step(rr, ri, re, rg, ra, rd);
    end

    idle(3, 4'h0);
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
